// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: FSM states, owner encoding, RAM size codes
// and a helper that sizes the latency counter.
package ram_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    OwnIf = 1'b0,
    OwnDm = 1'b1
  } arb_own_e;

  // Size codes understood by mem/ram.
  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } size_e;

  // Width needed to hold the values 0..lat.
  function automatic int unsigned cnt_width(int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker. Bit 0 is IF, bit 1 is DM.
// On a tie the requester that was not granted last wins.
module arb_rr2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_own_e   last_i,
  output logic [1:0] gnt_o
);

  // Pick at most one requester.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == OwnDm) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between instruction fetch (read-only) and
// load/store (read/write). Round-robin, one transaction in flight, a new
// grant may issue in the same cycle the previous one completes.
// Optional feature: define ARB_PERF_CNT_EN to add arb_conflict_cnt_o, a
// saturating count of cycles with an open slot and both requests high.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned AW      = XLEN,
  parameter int unsigned DW      = XLEN
) (
  input  logic          clk,
  input  logic          reset_n,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]   arb_conflict_cnt_o,
`endif
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_wen_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  input  logic [1:0]    dm_wmask_i,
  output logic          dm_gnt_o,
  output logic          dm_rvalid_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_wen_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic [1:0]    ram_wmask_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          arb_busy_o
);

  if (RAM_LAT == 0) begin : g_bad_lat
    $error("ram_arbiter: RAM_LAT must be at least 1");
  end

  localparam int unsigned     CntW   = cnt_width(RAM_LAT);
  localparam logic [CntW-1:0] CntMax = CntW'(RAM_LAT);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  arb_own_e        own_q, own_d;
  arb_own_e        last_q, last_d;
  logic            wr_q, wr_d;

  logic       busy;
  logic       complete;
  logic       slot_open;
  logic [1:0] req_vec;
  logic [1:0] pick;

  // Issue slot: idle, or the in-flight transaction finishes this cycle.
  // Gated by reset_n so nothing is granted while reset is held.
  always_comb begin
    busy      = (state_q == StWait);
    complete  = busy && (cnt_q == CntMax);
    slot_open = reset_n && (!busy || complete);
    req_vec   = {dm_req_i, if_req_i} & {2{slot_open}};
  end

  arb_rr2 u_arb_rr2 (
    .req_i  (req_vec),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // Grants, RAM request muxing and completion routing.
  always_comb begin
    if_gnt_o    = pick[0];
    dm_gnt_o    = pick[1];
    ram_addr_o  = '0;
    ram_wen_o   = 1'b0;
    ram_wdata_o = '0;
    ram_wmask_o = 2'b00;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_rvalid_o = 1'b0;
    dm_rdata_o  = '0;
    arb_busy_o  = busy;

    if (pick[0]) begin
      ram_addr_o  = if_addr_i;
      ram_wmask_o = SizeWord;
    end else if (pick[1]) begin
      ram_addr_o  = dm_addr_i;
      ram_wen_o   = dm_wen_i;
      ram_wdata_o = dm_wdata_i;
      ram_wmask_o = dm_wmask_i;
    end

    if (complete) begin
      if (own_q == OwnIf) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = ram_rdata_i;
      end else begin
        dm_rvalid_o = 1'b1;
        dm_rdata_o  = wr_q ? '0 : ram_rdata_i;
      end
    end
  end

  // Next state: a grant restarts the latency count; otherwise count up or
  // fall back to idle once the transaction completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    last_d  = last_q;
    wr_d    = wr_q;

    if (|pick) begin
      state_d = StWait;
      cnt_d   = CntW'(1);
      own_d   = pick[1] ? OwnDm : OwnIf;
      last_d  = pick[1] ? OwnDm : OwnIf;
      wr_d    = pick[1] & dm_wen_i;
    end else if (complete) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // State registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      own_q   <= OwnIf;
      last_q  <= OwnDm;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_q, conflict_d;

  // Saturating count of contested issue slots.
  always_comb begin
    conflict_d = conflict_q;
    if (slot_open && if_req_i && dm_req_i && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign arb_conflict_cnt_o = conflict_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one instance with RAM_LAT=1 (index 0), one with
// RAM_LAT=3 (index 1), each attached to a small latency-accurate RAM.
// Define ARB_PERF_CNT_EN to also exercise the conflict counter.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        dm_req    [2];
  logic        dm_wen    [2];
  logic [31:0] dm_addr   [2];
  logic [31:0] dm_wdata  [2];
  logic [1:0]  dm_wmask  [2];
  logic        dm_gnt    [2];
  logic        dm_rvalid [2];
  logic [31:0] dm_rdata  [2];
  logic [31:0] ram_addr  [2];
  logic        ram_wen   [2];
  logic [31:0] ram_wdata [2];
  logic [1:0]  ram_wmask [2];
  logic [31:0] ram_rdata [2];
  logic        busy      [2];
`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt [2];
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] shadow [2][256];

  ram_arbiter #(.RAM_LAT(1), .AW(32), .DW(32)) u_dut_l1 (
    .clk (clk), .reset_n (reset_n),
`ifdef ARB_PERF_CNT_EN
    .arb_conflict_cnt_o (conflict_cnt[0]),
`endif
    .if_req_i (if_req[0]), .if_addr_i (if_addr[0]), .if_gnt_o (if_gnt[0]),
    .if_rvalid_o (if_rvalid[0]), .if_rdata_o (if_rdata[0]),
    .dm_req_i (dm_req[0]), .dm_wen_i (dm_wen[0]), .dm_addr_i (dm_addr[0]),
    .dm_wdata_i (dm_wdata[0]), .dm_wmask_i (dm_wmask[0]), .dm_gnt_o (dm_gnt[0]),
    .dm_rvalid_o (dm_rvalid[0]), .dm_rdata_o (dm_rdata[0]),
    .ram_addr_o (ram_addr[0]), .ram_wen_o (ram_wen[0]), .ram_wdata_o (ram_wdata[0]),
    .ram_wmask_o (ram_wmask[0]), .ram_rdata_i (ram_rdata[0]), .arb_busy_o (busy[0])
  );

  ram_arbiter #(.RAM_LAT(3), .AW(32), .DW(32)) u_dut_l3 (
    .clk (clk), .reset_n (reset_n),
`ifdef ARB_PERF_CNT_EN
    .arb_conflict_cnt_o (conflict_cnt[1]),
`endif
    .if_req_i (if_req[1]), .if_addr_i (if_addr[1]), .if_gnt_o (if_gnt[1]),
    .if_rvalid_o (if_rvalid[1]), .if_rdata_o (if_rdata[1]),
    .dm_req_i (dm_req[1]), .dm_wen_i (dm_wen[1]), .dm_addr_i (dm_addr[1]),
    .dm_wdata_i (dm_wdata[1]), .dm_wmask_i (dm_wmask[1]), .dm_gnt_o (dm_gnt[1]),
    .dm_rvalid_o (dm_rvalid[1]), .dm_rdata_o (dm_rdata[1]),
    .ram_addr_o (ram_addr[1]), .ram_wen_o (ram_wen[1]), .ram_wdata_o (ram_wdata[1]),
    .ram_wmask_o (ram_wmask[1]), .ram_rdata_i (ram_rdata[1]), .arb_busy_o (busy[1])
  );

  function automatic logic [31:0] pattern(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // RAM models: write in the grant cycle, read data appears RAM_LAT cycles later.
  logic [31:0] mem  [2][256];
  logic [31:0] pipe [2][3];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int k = 0; k < 2; k++) for (int i = 0; i < 256; i++) mem[k][i] <= pattern(i);
      ram_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ram_wen[k]) mem[k][ram_addr[k][9:2]] <= ram_wdata[k];
        pipe[k][0] <= mem[k][ram_addr[k][9:2]];
        pipe[k][1] <= pipe[k][0];
        pipe[k][2] <= pipe[k][1];
      end
    end
  end
  assign ram_rdata[0] = pipe[0][0];
  assign ram_rdata[1] = pipe[1][2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      dm_req[k] = 1'b0; dm_wen[k] = 1'b0; dm_addr[k] = '0;
      dm_wdata[k] = '0; dm_wmask[k] = 2'b10;
    end
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset.
  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b1; dm_req[k] = 1'b1; if_addr[k] = 32'h44; dm_addr[k] = 32'h48;
    end
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({if_gnt[k], dm_gnt[k]} !== 2'b00)
        $display("FAIL reset_gnt k=%0d got %b exp 00", k, {if_gnt[k], dm_gnt[k]});
      else n_pass++;
      n_checks++;
      if ({if_rvalid[k], dm_rvalid[k], if_rdata[k], dm_rdata[k], ram_addr[k], ram_wen[k],
           ram_wdata[k], ram_wmask[k], busy[k]} !== '0)
        $display("FAIL reset_outs k=%0d got rv=%b%b addr=%h wen=%b busy=%b exp all 0", k,
                 if_rvalid[k], dm_rvalid[k], ram_addr[k], ram_wen[k], busy[k]);
      else n_pass++;
`ifdef ARB_PERF_CNT_EN
      n_checks++;
      if (conflict_cnt[k] !== 32'd0)
        $display("FAIL reset_conflict k=%0d got %0d exp 0", k, conflict_cnt[k]);
      else n_pass++;
`endif
    end
    idle_inputs();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single_if();
    if_req[0] = 1'b1; if_addr[0] = 32'h100;
    @(negedge clk);
    n_checks++;
    if ({if_gnt[0], dm_gnt[0], ram_wen[0], ram_addr[0]} !== {3'b100, 32'h100})
      $display("FAIL single_if_grant got gnt=%b addr=%h exp gnt=1 addr=100", if_gnt[0], ram_addr[0]);
    else n_pass++;
    tick();
    if_req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({if_rvalid[0], if_gnt[0], if_rdata[0]} !== {2'b10, shadow[0][64]})
      $display("FAIL single_if_rdata got rv=%b data=%h exp rv=1 data=%h", if_rvalid[0],
               if_rdata[0], shadow[0][64]);
    else n_pass++;
    tick();
  endtask

  task automatic test_tie();
    logic exp_if;
    do_reset();
    if_req[0] = 1'b1; if_addr[0] = 32'h8;
    dm_req[0] = 1'b1; dm_wen[0] = 1'b0; dm_addr[0] = 32'hC;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_if = (c % 2 == 0);
      n_checks++;
      if ({if_gnt[0], dm_gnt[0]} !== {exp_if, !exp_if})
        $display("FAIL tie_gnt c=%0d got if=%b dm=%b exp if=%b dm=%b", c, if_gnt[0], dm_gnt[0],
                 exp_if, !exp_if);
      else n_pass++;
      if (c > 0) begin
        n_checks++;
        if (exp_if ? ({dm_rvalid[0], dm_rdata[0]} !== {1'b1, shadow[0][3]})
                   : ({if_rvalid[0], if_rdata[0]} !== {1'b1, shadow[0][2]}))
          $display("FAIL tie_rvalid c=%0d got if=%b/%h dm=%b/%h", c, if_rvalid[0], if_rdata[0],
                   dm_rvalid[0], dm_rdata[0]);
        else n_pass++;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    dm_req[0] = 1'b1; dm_wen[0] = 1'b1; dm_addr[0] = 32'h40;
    dm_wdata[0] = 32'hDEAD_BEEF; dm_wmask[0] = 2'b10;
    @(negedge clk);
    n_checks++;
    if ({dm_gnt[0], ram_wen[0], ram_addr[0], ram_wdata[0], ram_wmask[0]} !==
        {2'b11, 32'h40, 32'hDEAD_BEEF, 2'b10})
      $display("FAIL write_issue got gnt=%b wen=%b addr=%h wdata=%h wmask=%b", dm_gnt[0],
               ram_wen[0], ram_addr[0], ram_wdata[0], ram_wmask[0]);
    else n_pass++;
    shadow[0][16] = 32'hDEAD_BEEF;
    tick();
    dm_wen[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dm_rvalid[0], dm_rdata[0], dm_gnt[0], ram_wen[0]} !== {1'b1, 32'h0, 2'b10})
      $display("FAIL write_ack got rv=%b data=%h gnt=%b wen=%b exp 1/0/1/0", dm_rvalid[0],
               dm_rdata[0], dm_gnt[0], ram_wen[0]);
    else n_pass++;
    tick();
    dm_req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dm_rvalid[0], dm_rdata[0]} !== {1'b1, 32'hDEAD_BEEF})
      $display("FAIL read_back got rv=%b data=%h exp 1/deadbeef", dm_rvalid[0], dm_rdata[0]);
    else n_pass++;
    tick();
  endtask

  task automatic test_lat3_stream();
    logic eg, er, eb;
    do_reset();
    if_req[1] = 1'b1; if_addr[1] = 32'h20;
    for (int c = 0; c <= 12; c++) begin
      if (c == 10) if_req[1] = 1'b0;
      @(negedge clk);
      eg = (c < 10) && (c % 3 == 0);
      er = (c > 0) && (c % 3 == 0);
      eb = (c > 0);
      n_checks++;
      if ({if_gnt[1], if_rvalid[1], busy[1]} !== {eg, er, eb})
        $display("FAIL lat3_stream c=%0d got gnt/rv/busy=%b%b%b exp %b%b%b", c, if_gnt[1],
                 if_rvalid[1], busy[1], eg, er, eb);
      else n_pass++;
      if (er) begin
        n_checks++;
        if (if_rdata[1] !== shadow[1][8])
          $display("FAIL lat3_rdata c=%0d got %h exp %h", c, if_rdata[1], shadow[1][8]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    if_req[1] = 1'b1; if_addr[1] = 32'h30;
    @(negedge clk);
    n_checks++;
    if (if_gnt[1] !== 1'b1) $display("FAIL inflight_grant got %b exp 1", if_gnt[1]);
    else n_pass++;
    tick();
    if_addr[1] = 32'h34;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({if_gnt[1], if_rvalid[1], busy[1], ram_addr[1], if_rdata[1]} !== '0)
      $display("FAIL inflight_reset_outs got gnt=%b rv=%b busy=%b addr=%h exp all 0", if_gnt[1],
               if_rvalid[1], busy[1], ram_addr[1]);
    else n_pass++;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({if_rvalid[1], if_gnt[1]} !== 2'b00)
        $display("FAIL inflight_no_rvalid c=%0d got rv=%b gnt=%b exp 00", c, if_rvalid[1],
                 if_gnt[1]);
      else n_pass++;
      tick();
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({if_gnt[1], ram_addr[1]} !== {1'b1, 32'h34})
      $display("FAIL post_reset_grant got gnt=%b addr=%h exp 1/34", if_gnt[1], ram_addr[1]);
    else n_pass++;
    tick();
    if_req[1] = 1'b0;
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      n_checks++;
      if ({if_rvalid[1], if_rdata[1]} !== ((c == 7) ? {1'b1, shadow[1][13]} : 33'd0))
        $display("FAIL post_reset_rvalid c=%0d got %b/%h", c, if_rvalid[1], if_rdata[1]);
      else n_pass++;
      tick();
    end
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    if_req[0] = 1'b1; if_addr[0] = 32'h0;
    dm_req[0] = 1'b1; dm_wen[0] = 1'b0; dm_addr[0] = 32'h4;
    repeat (4) tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (conflict_cnt[0] !== 32'd4)
      $display("FAIL conflict_cnt got %0d exp 4", conflict_cnt[0]);
    else n_pass++;
    tick();
  endtask
`endif

  // Random traffic against a cycle-level reference: slots open RAM_LAT cycles
  // after a grant, ties alternate, data comes from a shadow copy of the RAM.
  task automatic test_random(int k, int n);
    int          lat = lat_of(k);
    int          next_open = 0;
    int          done_c = -1;
    bit          last_dm = 1'b1;
    bit          pend = 1'b0, pend_dm = 1'b0;
    bit          if_seen = 1'b0, dm_seen = 1'b0;
    bit          open, e_if, e_dm, e_ifrv, e_dmrv;
    logic [31:0] pend_data, e_addr;
    int          idx;
    do_reset();
    for (int c = 0; c < n; c++) begin
      if (!if_req[k] || if_seen) begin
        if (c < n - 4 && $urandom_range(1) == 1) begin
          if_req[k] = 1'b1; if_addr[k] = {22'd0, 8'($urandom_range(255)), 2'b00};
        end else if_req[k] = 1'b0;
      end else if ($urandom_range(7) == 0) if_req[k] = 1'b0;
      if (!dm_req[k] || dm_seen) begin
        if (c < n - 4 && $urandom_range(1) == 1) begin
          dm_req[k] = 1'b1; dm_wen[k] = 1'($urandom_range(1));
          dm_addr[k] = {22'd0, 8'($urandom_range(255)), 2'b00}; dm_wdata[k] = $urandom;
        end else dm_req[k] = 1'b0;
      end else if ($urandom_range(7) == 0) dm_req[k] = 1'b0;
      @(negedge clk);
      open   = (c >= next_open);
      e_if   = open && if_req[k] && (!dm_req[k] || last_dm);
      e_dm   = open && dm_req[k] && (!if_req[k] || !last_dm);
      e_ifrv = pend && !pend_dm && (c == done_c);
      e_dmrv = pend && pend_dm && (c == done_c);
      e_addr = e_if ? if_addr[k] : (e_dm ? dm_addr[k] : 32'h0);
      n_checks++;
      if ({if_gnt[k], dm_gnt[k], ram_wen[k], ram_addr[k]} !==
          {e_if, e_dm, e_dm && dm_wen[k], e_addr})
        $display("FAIL rand_issue k=%0d c=%0d got gnt=%b%b wen=%b addr=%h exp %b%b %b %h", k, c,
                 if_gnt[k], dm_gnt[k], ram_wen[k], ram_addr[k], e_if, e_dm, e_dm && dm_wen[k],
                 e_addr);
      else n_pass++;
      n_checks++;
      if ({if_rvalid[k], if_rdata[k], dm_rvalid[k], dm_rdata[k]} !==
          {e_ifrv, e_ifrv ? pend_data : 32'h0, e_dmrv, e_dmrv ? pend_data : 32'h0})
        $display("FAIL rand_resp k=%0d c=%0d got if=%b/%h dm=%b/%h exp if=%b dm=%b data=%h", k,
                 c, if_rvalid[k], if_rdata[k], dm_rvalid[k], dm_rdata[k], e_ifrv, e_dmrv,
                 pend_data);
      else n_pass++;
      if (c == done_c) pend = 1'b0;
      if (e_if || e_dm) begin
        idx       = int'(e_addr[9:2]);
        pend      = 1'b1;
        pend_dm   = e_dm;
        done_c    = c + lat;
        next_open = c + lat;
        last_dm   = e_dm;
        pend_data = (e_dm && dm_wen[k]) ? 32'h0 : shadow[k][idx];
        if (e_dm && dm_wen[k]) shadow[k][idx] = dm_wdata[k];
      end
      if_seen = if_gnt[k];
      dm_seen = dm_gnt[k];
      tick();
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) for (int i = 0; i < 256; i++) shadow[k][i] = pattern(i);
    test_reset();
    test_single_if();
    test_tie();
    test_write_read();
    test_lat3_stream();
    test_reset_inflight();
`ifdef ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random(0, 300);
    test_random(1, 300);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
